// File: rtl/comb_checker.sv
// Exhaustive 4-input sweep checker: steps vec through 0..15, holds each vector
// for DWELL cycles, then samples four responses and records disagreements.
module comb_checker #(
  parameter int unsigned DWELL = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  resp,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic [15:0] tt,
  output logic [15:0] mismatch,
  output logic [4:0]  err_cnt,
  output logic        pass,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e      state_q;
  logic [3:0]  vec_q;
  logic [7:0]  cnt_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] tt_q;
  logic [15:0] mismatch_q;
  logic [4:0]  err_cnt_q;
  logic        pass_q;

  logic        resp_bad;
  logic [4:0]  err_cnt_d;

  // A response set disagrees unless all four implementations return the same bit.
  always_comb begin
    resp_bad  = (resp != 4'b0000) && (resp != 4'b1111);
    err_cnt_d = err_cnt_q + {4'b0000, resp_bad};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= 4'd0;
      cnt_q      <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tt_q       <= 16'd0;
      mismatch_q <= 16'd0;
      err_cnt_q  <= 5'd0;
      pass_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= DRIVE;
            busy_q     <= 1'b1;
            vec_q      <= 4'd0;
            cnt_q      <= 8'd0;
            tt_q       <= 16'd0;
            mismatch_q <= 16'd0;
            err_cnt_q  <= 5'd0;
            pass_q     <= 1'b0;
          end
        end
        DRIVE: begin
          if (cnt_q == DWELL_LAST) begin
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        SAMPLE: begin
          tt_q[vec_q]       <= resp[0];
          mismatch_q[vec_q] <= resp_bad;
          err_cnt_q         <= err_cnt_d;
          cnt_q             <= 8'd0;
          // vec wraps from 15 to 0 here, which is the value DONE presents.
          vec_q             <= vec_q + 4'd1;
          if (vec_q == 4'd15) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_cnt_d == 5'd0);
          end else begin
            state_q <= DRIVE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec       = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign tt        = tt_q;
  assign mismatch  = mismatch_q;
  assign err_cnt   = err_cnt_q;
  assign pass      = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_comb_checker.sv
// Bench for comb_checker: one DWELL=4 and one DWELL=1 instance, modelled
// responders, and a queue of expected sweep results checked at each done.
module tb_comb_checker;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sel;
  logic [3:0]  resp;

  logic        start_a, start_b;
  logic [3:0]  vec_a, vec_b;
  logic        busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [15:0] tt_a, tt_b, mm_a, mm_b;
  logic [4:0]  err_a, err_b;
  logic [1:0]  st_a, st_b;

  logic [3:0]  vec_o;
  logic        busy_o, done_o, pass_o;
  logic [15:0] tt_o, mm_o;
  logic [4:0]  err_o;

  assign start_a = start & ~sel;
  assign start_b = start & sel;
  assign vec_o   = sel ? vec_b  : vec_a;
  assign busy_o  = sel ? busy_b : busy_a;
  assign done_o  = sel ? done_b : done_a;
  assign pass_o  = sel ? pass_b : pass_a;
  assign tt_o    = sel ? tt_b   : tt_a;
  assign mm_o    = sel ? mm_b   : mm_a;
  assign err_o   = sel ? err_b  : err_a;

  comb_checker #(.DWELL(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .start(start_a), .resp(resp), .vec(vec_a),
    .busy(busy_a), .done(done_a), .tt(tt_a), .mismatch(mm_a),
    .err_cnt(err_a), .pass(pass_a), .dbg_state(st_a)
  );

  comb_checker #(.DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .start(start_b), .resp(resp), .vec(vec_b),
    .busy(busy_b), .done(done_b), .tt(tt_b), .mismatch(mm_b),
    .err_cnt(err_b), .pass(pass_b), .dbg_state(st_b)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_tt_q[$];
  logic [15:0] exp_mm_q[$];
  logic [4:0]  exp_err_q[$];
  logic        exp_pass_q[$];

  // Responder model: mode 0 all agree on parity, mode 1 prim stuck at 0,
  // mode 2 random noise except on the sampled cycle.
  function automatic logic [3:0] model_resp(input int mode, input logic [3:0] v,
                                            input bit sample_cyc);
    logic p;
    p = ^v;
    case (mode)
      0:       return {4{p}};
      1:       return {1'b0, p, p, p};
      default: return sample_cyc ? {4{p}} : 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Starts at a negedge in IDLE; ends at the negedge of the IDLE cycle after DONE.
  task automatic run_sweep(input int d, input int mode, input bit hold_start,
                           input bit poke);
    int          total;
    int          v;
    int          p;
    logic [15:0] mm_e;
    logic [15:0] tt_e;
    logic [3:0]  iv;
    logic [15:0] g_tt, g_mm;
    logic [4:0]  g_err;
    logic        g_pass;
    total = 16 * (d + 1);
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      tt_e[i] = ^iv;
      mm_e[i] = (mode == 1) && (^iv);
    end
    exp_tt_q.push_back(tt_e);
    exp_mm_q.push_back(mm_e);
    exp_err_q.push_back(5'($countones(mm_e)));
    exp_pass_q.push_back(mm_e == 16'd0);

    start = 1'b1;
    resp  = 4'd0;
    @(negedge clk);
    for (int k = 1; k <= total; k++) begin
      v = (k - 1) / (d + 1);
      p = (k - 1) % (d + 1);
      n_cmp++;
      if (vec_o !== v[3:0]) begin
        n_bad++;
        $display("FAIL sweep_vec d=%0d k=%0d: got %0d expected %0d", d, k, vec_o, v);
      end
      n_cmp++;
      if (busy_o !== 1'b1 || done_o !== 1'b0) begin
        n_bad++;
        $display("FAIL sweep_busy d=%0d k=%0d: got busy=%b done=%b expected busy=1 done=0",
                 d, k, busy_o, done_o);
      end
      resp = model_resp(mode, v[3:0], p == d);
      if (!hold_start) start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end

    if (!hold_start) start = 1'b0;
    n_cmp++;
    if (done_o !== 1'b1 || busy_o !== 1'b0 || vec_o !== 4'd0) begin
      n_bad++;
      $display("FAIL done_cycle d=%0d: got done=%b busy=%b vec=%0d expected done=1 busy=0 vec=0",
               d, done_o, busy_o, vec_o);
    end
    g_tt   = exp_tt_q.pop_front();
    g_mm   = exp_mm_q.pop_front();
    g_err  = exp_err_q.pop_front();
    g_pass = exp_pass_q.pop_front();
    @(negedge clk);
    n_cmp++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after d=%0d: got done=%b busy=%b expected done=0 busy=0",
               d, done_o, busy_o);
    end
    n_cmp++;
    if (tt_o !== g_tt) begin
      n_bad++;
      $display("FAIL tt d=%0d mode=%0d: got %h expected %h", d, mode, tt_o, g_tt);
    end
    n_cmp++;
    if (mm_o !== g_mm) begin
      n_bad++;
      $display("FAIL mismatch d=%0d mode=%0d: got %h expected %h", d, mode, mm_o, g_mm);
    end
    n_cmp++;
    if (err_o !== g_err) begin
      n_bad++;
      $display("FAIL err_cnt d=%0d mode=%0d: got %0d expected %0d", d, mode, err_o, g_err);
    end
    n_cmp++;
    if (pass_o !== g_pass) begin
      n_bad++;
      $display("FAIL pass d=%0d mode=%0d: got %b expected %b", d, mode, pass_o, g_pass);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    sel   = 1'b0;
    resp  = 4'd0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_cmp++;
      if ({vec_o, busy_o, done_o, tt_o, mm_o, err_o, pass_o} !== '0) begin
        n_bad++;
        $display("FAIL reset_state sel=%0d: got vec=%0d busy=%b done=%b tt=%h mm=%h err=%0d pass=%b expected all 0",
                 s, vec_o, busy_o, done_o, tt_o, mm_o, err_o, pass_o);
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sweep_agree();
    sel = 1'b0;
    run_sweep(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stuck_prim();
    sel = 1'b0;
    run_sweep(4, 1, 1'b0, 1'b0);
  endtask

  task automatic test_drive_noise();
    sel = 1'b0;
    run_sweep(4, 2, 1'b0, 1'b0);
  endtask

  task automatic test_mid_reset();
    int done_seen;
    sel   = 1'b0;
    start = 1'b1;
    resp  = 4'd0;
    @(negedge clk);
    for (int k = 1; k <= 35; k++) begin
      start = 1'b0;
      resp  = model_resp(0, vec_o, 1'b1);
      @(negedge clk);
    end
    n_cmp++;
    if (vec_o !== 4'd7 || busy_o !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_vec: got vec=%0d busy=%b expected vec=7 busy=1", vec_o, busy_o);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vec_o, busy_o, done_o, tt_o, mm_o, err_o, pass_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got vec=%0d busy=%b done=%b tt=%h mm=%h err=%0d pass=%b expected all 0",
               vec_o, busy_o, done_o, tt_o, mm_o, err_o, pass_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done_o !== 1'b0 || busy_o !== 1'b0) done_seen++;
    end
    n_cmp++;
    if (done_seen != 0) begin
      n_bad++;
      $display("FAIL aborted_sweep: got %0d active cycles expected 0", done_seen);
    end
    run_sweep(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    run_sweep(4, 0, 1'b1, 1'b0);
    run_sweep(4, 1, 1'b1, 1'b0);
    run_sweep(4, 0, 1'b0, 1'b0);
  endtask

  task automatic test_busy_pokes();
    sel = 1'b0;
    run_sweep(4, 1, 1'b0, 1'b1);
    @(negedge clk);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_bad++;
      $display("FAIL extra_sweep: got busy=%b expected 0", busy_o);
    end
  endtask

  task automatic test_dwell1();
    sel = 1'b1;
    run_sweep(1, 0, 1'b0, 1'b0);
    run_sweep(1, 1, 1'b0, 1'b0);
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep_agree();
    test_stuck_prim();
    test_drive_noise();
    test_mid_reset();
    test_back_to_back();
    test_busy_pokes();
    test_dwell1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/comb_checker.md
COMB_CHECKER -- requirements
Module: comb_checker

Interface
REQ-001 Parameter: DWELL, default 4, number of clock cycles each test vector is held before its response is sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request one exhaustive sweep; sampled only in IDLE.
REQ-005 vec  output  4  test vector {D,C,B,A} driven to the four implementations under test.
REQ-006 resp  input  4  responses; bit0 str, bit1 dataflow, bit2 behavior, bit3 prim.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse at sweep completion.
REQ-009 tt  output  16  captured truth table of resp[0]; bit i = resp[0] sampled at vec=i.
REQ-010 mismatch  output  16  bit i set if the four responses disagreed at vec=i.
REQ-011 err_cnt  output  5  number of vectors with disagreement, 0..16.
REQ-012 pass  output  1  high after a sweep with err_cnt=0; held until next start is accepted.

Function
REQ-013 The block SHALL implement FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-014 IDLE: busy=0, vec=0; on an edge with start=1, go to DRIVE, clear tt, mismatch, err_cnt, pass and the dwell counter; this is the accept edge.
REQ-015 DRIVE: hold vec for exactly DWELL cycles, then go to SAMPLE.
REQ-016 SAMPLE: vec still held; on the exiting edge, tt[vec] <= resp[0]; mismatch[vec] <= (resp != 4'b0000 && resp != 4'b1111); err_cnt increments by 1 iff that mismatch is set.
REQ-017 After SAMPLE: if vec<15, vec increments by 1 and the FSM returns to DRIVE with the dwell counter cleared; if vec=15, the FSM goes to DONE.
REQ-018 Only the value of resp on the SAMPLE exit edge SHALL be used; resp during DRIVE cycles is ignored.
REQ-019 Each vector SHALL occupy DWELL+1 cycles; done SHALL be high in the cycle starting 16*(DWELL+1) edges after the accept edge.
REQ-020 DONE lasts exactly one cycle: done=1, busy=0, pass <= (err_cnt==0), vec returns to 0; next state IDLE unconditionally.
REQ-021 busy SHALL be 1 from the accept edge through the last SAMPLE cycle, and 0 otherwise.
REQ-022 start SHALL be ignored in DRIVE, SAMPLE and DONE; a held-high start launches a new sweep on the first IDLE edge after DONE.
REQ-023 tt, mismatch, err_cnt and pass SHALL hold their values from DONE until the next accept edge.
REQ-024 err_cnt SHALL not wrap; 5 bits covers the maximum value of 16.

Reset
REQ-025 While rst_n=0, the block SHALL force, asynchronously: state IDLE, vec=0, busy=0, done=0, tt=0, mismatch=0, err_cnt=0, pass=0, dwell counter=0.
REQ-026 Reset asserted mid-sweep SHALL abort the sweep with no done pulse; the first start after release runs a full sweep from vec=0.

Verification
REQ-027 DWELL=4, all resp bits = ^vec; pulse start -> vec steps 0..15, 5 cycles each; done 80 edges after accept; tt=16'h6996, mismatch=0, err_cnt=0, pass=1.
REQ-028 DWELL=4, resp[3] stuck 0, others = ^vec -> tt=16'h6996, mismatch=16'h6996, err_cnt=8, pass=0.
REQ-029 rst_n pulsed low while vec=7 -> all outputs 0 immediately, no done pulse; the next start yields a clean full sweep with the scenario REQ-027 results.
REQ-030 start held high continuously -> back-to-back sweeps, each with exactly one done pulse, separated by one IDLE cycle; start pulses during busy produce no extra sweep.
REQ-031 DWELL=1 -> each vec held 2 cycles; done 32 edges after accept.
REQ-032 resp bits disagree during DRIVE cycles only and agree on the SAMPLE edge -> mismatch=0, err_cnt=0, pass=1.
